// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the byte and word ALUs.
//   - kALU_* operation codes (3 bits)
//   - word-sequencer state encoding (IDLE, RUN, DONE)
//   - idx_width(): byte-index register width, clog2 with a minimum of 1
//   - bcd_corr(): per-nibble decimal correction term
package alu_pkg;

    localparam logic [2:0] kALU_ORA = 3'd0;
    localparam logic [2:0] kALU_AND = 3'd1;
    localparam logic [2:0] kALU_EOR = 3'd2;
    localparam logic [2:0] kALU_ADC = 3'd3;
    localparam logic [2:0] kALU_SHR = 3'd4;
    localparam logic [2:0] kALU_ASR = 3'd5;
    localparam logic [2:0] kALU_SHL = 3'd6;
    localparam logic [2:0] kALU_RSV = 3'd7;  // reserved: pass A, carry passes through

    // Sequencer states, kept as plain constants so legacy code can share the encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Decimal correction added to a nibble once its carry is known.
    // Add and subtract adjustments are mutually exclusive (carry vs. no carry).
    function automatic logic [3:0] bcd_corr(input logic carry, input logic dec_add,
                                            input logic dec_sub);
        logic add_adj;
        logic sub_adj;
        add_adj = dec_add & carry;
        sub_adj = dec_sub & ~carry;
        return {sub_adj, add_adj, add_adj | sub_adj, 1'b0};
    endfunction

endpackage

// File: rtl/alu_word_seq_if.sv
// alu_word_seq_if: request/response bundle of the word-sequential ALU.
//   master (requester): drives start, op, a, b, c_in, dec_add, dec_sub
//   slave  (ALU):       drives busy, done, result, c_out, v_out, n_out, z_out
interface alu_word_seq_if #(
    parameter int unsigned WORD_BYTES = 2
);
    localparam int unsigned W = 8 * WORD_BYTES;

    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;        // pre-inverted by the caller for subtract
    logic         c_in;     // carry in / shift fill
    logic         dec_add;
    logic         dec_sub;

    logic         busy;
    logic         done;     // one-cycle pulse: result and flags valid
    logic [W-1:0] result;
    logic         c_out;
    logic         v_out;
    logic         n_out;
    logic         z_out;

    modport master (
        output start, op, a, b, c_in, dec_add, dec_sub,
        input  busy, done, result, c_out, v_out, n_out, z_out
    );

    modport slave (
        input  start, op, a, b, c_in, dec_add, dec_sub,
        output busy, done, result, c_out, v_out, n_out, z_out
    );

endinterface

// File: rtl/alu_byte_slice.sv
// alu_byte_slice: combinational 8-bit ALU slice with decimal add/subtract correction.
//   a8_i, b8_i     byte operands
//   cin_i          chain in: carry for ADC/logic ops, fill bit for shifts
//   op_i           kALU_* operation code
//   dec_add_i/sub  BCD correction enables
//   y8_o           byte result
//   chain_o        chain out: byte carry for ADC/logic ops, shifted-out bit for shifts
module alu_byte_slice
    import alu_pkg::*;
(
    input  logic [7:0] a8_i,
    input  logic [7:0] b8_i,
    input  logic       cin_i,
    input  logic [2:0] op_i,
    input  logic       dec_add_i,
    input  logic       dec_sub_i,
    output logic [7:0] y8_o,
    output logic       chain_o
);

    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic       lo_c;
    logic       hi_c;
    logic [3:0] lo_y;
    logic [3:0] hi_y;

    always_comb begin
        lo_sum = {1'b0, a8_i[3:0]} + {1'b0, b8_i[3:0]} + {4'b0, cin_i};
        // Decimal mode forces a carry out of any nibble above 9.
        lo_c   = lo_sum[4] | (dec_add_i & (lo_sum > 5'd9));
        lo_y   = lo_sum[3:0] + bcd_corr(lo_c, dec_add_i, dec_sub_i);

        hi_sum = {1'b0, a8_i[7:4]} + {1'b0, b8_i[7:4]} + {4'b0, lo_c};
        hi_c   = hi_sum[4] | (dec_add_i & (hi_sum > 5'd9));
        hi_y   = hi_sum[3:0] + bcd_corr(hi_c, dec_add_i, dec_sub_i);
    end

    always_comb begin
        y8_o    = a8_i;
        chain_o = cin_i;
        case (op_i)
            // Logic ops still report the adder carry of the same operands.
            kALU_ORA: begin y8_o = a8_i | b8_i;  chain_o = hi_c;    end
            kALU_AND: begin y8_o = a8_i & b8_i;  chain_o = hi_c;    end
            kALU_EOR: begin y8_o = a8_i ^ b8_i;  chain_o = hi_c;    end
            kALU_ADC: begin y8_o = {hi_y, lo_y}; chain_o = hi_c;    end
            kALU_SHR,
            kALU_ASR: begin y8_o = {cin_i, a8_i[7:1]}; chain_o = a8_i[0]; end
            kALU_SHL: begin y8_o = {a8_i[6:0], cin_i}; chain_o = a8_i[7]; end
            default:  begin y8_o = a8_i;         chain_o = cin_i;   end
        endcase
    end

endmodule

// File: rtl/alu_word_seq.sv
// alu_word_seq: word-wide ALU executing one byte per clock through a shared byte slice.
//   clk    core clock
//   reset  asynchronous active-high reset
//   bus    alu_word_seq_if slave: start/op/operands in, busy/done/result/flags out
// A start seen in IDLE or DONE latches the request; RUN processes WORD_BYTES bytes
// (LSB first, or MSB first for right shifts) chaining carry/shift bits; DONE pulses
// for one cycle with result and flags, which then hold until the next accepted start.
module alu_word_seq
    import alu_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_word_seq_if.slave bus
);

    localparam int unsigned W  = 8 * WORD_BYTES;
    localparam int unsigned IW = idx_width(WORD_BYTES);
    localparam logic [IW-1:0] LastIdx = IW'(WORD_BYTES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          chain_q, chain_d;
    logic          zero_q, zero_d;     // all bytes so far were zero
    logic [W-1:0]  res_q, res_d;
    logic          c_q, c_d;
    logic          v_q, v_d;
    logic          n_q, n_d;
    logic          z_q, z_d;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [2:0]    op_q;
    logic          dec_add_q;
    logic          dec_sub_q;

    logic          accept;
    logic          desc;
    logic          desc_start;
    logic          last_byte;
    logic [7:0]    a8;
    logic [7:0]    b8;
    logic [7:0]    y8;
    logic          chain_out;

    assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign desc       = (op_q == kALU_SHR) || (op_q == kALU_ASR);
    assign desc_start = (bus.op == kALU_SHR) || (bus.op == kALU_ASR);
    assign last_byte  = desc ? (idx_q == '0) : (idx_q == LastIdx);

    // Select the byte under the current index.
    always_comb begin
        a8 = '0;
        b8 = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (idx_q == IW'(i)) begin
                a8 = a_q[8*i +: 8];
                b8 = b_q[8*i +: 8];
            end
        end
    end

    alu_byte_slice u_slice (
        .a8_i      (a8),
        .b8_i      (b8),
        .cin_i     (chain_q),
        .op_i      (op_q),
        .dec_add_i (dec_add_q),
        .dec_sub_i (dec_sub_q),
        .y8_o      (y8),
        .chain_o   (chain_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chain_d = chain_q;
        zero_d  = zero_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;

        case (state_q)
            RUN: begin
                for (int i = 0; i < int'(WORD_BYTES); i++) begin
                    if (idx_q == IW'(i)) begin
                        res_d[8*i +: 8] = y8;
                    end
                end
                chain_d = chain_out;
                zero_d  = zero_q & (y8 == 8'd0);
                if (last_byte) begin
                    state_d = DONE;
                    c_d     = chain_out;
                    n_d     = res_d[W-1];
                    z_d     = zero_d;
                    v_d     = (a_q[W-1] == b_q[W-1]) && (a_q[W-1] != res_d[W-1]);
                end else begin
                    idx_d = desc ? (idx_q - IW'(1)) : (idx_q + IW'(1));
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    idx_d   = desc_start ? LastIdx : '0;
                    // Arithmetic right shift fills the top byte with the sign bit.
                    chain_d = (bus.op == kALU_ASR) ? bus.a[W-1] : bus.c_in;
                    zero_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            chain_q   <= 1'b0;
            zero_q    <= 1'b0;
            res_q     <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            dec_add_q <= 1'b0;
            dec_sub_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chain_q <= chain_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            if (accept) begin
                a_q       <= bus.a;
                b_q       <= bus.b;
                op_q      <= bus.op;
                dec_add_q <= bus.dec_add;
                dec_sub_q <= bus.dec_sub;
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = res_q;
    assign bus.c_out  = c_q;
    assign bus.v_out  = v_q;
    assign bus.n_out  = n_q;
    assign bus.z_out  = z_q;

endmodule

// File: tb/tb_alu_word_seq.sv
// tb_alu_word_seq: directed bench for alu_word_seq (WORD_BYTES=2) with a word-level model.
module tb_alu_word_seq;
    import alu_pkg::*;

    localparam int unsigned WB = 2;
    localparam int unsigned W  = 8 * WB;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flags;  // {c, v, n, z}
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_word_seq_if #(.WORD_BYTES(WB)) bus ();

    alu_word_seq #(.WORD_BYTES(WB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Word-level reference: nibble-serial decimal adder, whole-word logic and shifts.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin,
                                   input logic da, input logic ds);
        exp_t         e;
        logic [W-1:0] sum;
        logic [W-1:0] r;
        logic         cy;
        logic         c;
        int           s;
        cy  = cin;
        sum = '0;
        for (int k = 0; k < int'(W / 4); k++) begin
            s  = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + int'(cy);
            cy = (s > 15) || (da && s > 9);
            if (da && cy) s = s + 6;
            if (ds && !cy) s = s + 10;
            sum[4*k +: 4] = 4'(s);
        end
        case (op)
            kALU_ORA: begin r = a | b; c = cy; end
            kALU_AND: begin r = a & b; c = cy; end
            kALU_EOR: begin r = a ^ b; c = cy; end
            kALU_ADC: begin r = sum;   c = cy; end
            kALU_SHR: begin r = {cin, a[W-1:1]};    c = a[0];   end
            kALU_ASR: begin r = {a[W-1], a[W-1:1]}; c = a[0];   end
            kALU_SHL: begin r = {a[W-2:0], cin};    c = a[W-1]; end
            default:  begin r = a; c = cin; end
        endcase
        e.res   = r;
        e.flags = {c, (a[W-1] == b[W-1]) && (a[W-1] != r[W-1]), r[W-1], r == '0};
        return e;
    endfunction

    // Every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            exp_t e;
            done_seen++;
            if (expq.size() == 0) begin
                chk("done_without_request", expq.size(), 1);
            end else begin
                e = expq.pop_front();
                chk("result", bus.result, e.res);
                chk("flags_cvnz", {bus.c_out, bus.v_out, bus.n_out, bus.z_out}, e.flags);
                chk("busy_during_done", bus.busy, 1'b0);
            end
        end
    end

    // Called at a negedge with the DUT idle or done; returns at the negedge showing done.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input logic da,
                          input logic ds, input logic [W-1:0] want_res,
                          input logic [3:0] want_flags, input bit poke);
        exp_t e;
        int   cnt;
        bit   got;
        e = model(op, a, b, cin, da, ds);
        chk($sformatf("%s_model_res", name), e.res, want_res);
        chk($sformatf("%s_model_cvnz", name), e.flags, want_flags);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.c_in    = cin;
        bus.dec_add = da;
        bus.dec_sub = ds;
        @(posedge clk);
        expq.push_back(e);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                chk($sformatf("%s_busy_done", name), {bus.busy, bus.done}, 2'b10);
                // Scramble inputs; with poke, also raise start while RUN.
                bus.start   = poke;
                bus.op      = 3'($urandom);
                bus.a       = W'($urandom);
                bus.b       = W'($urandom);
                bus.c_in    = 1'($urandom);
                bus.dec_add = 1'($urandom);
                bus.dec_sub = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            got = bus.done;
        end
        chk($sformatf("%s_latency", name), cnt, WB + 1);
        if (!got) expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ds0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.a       = '0;
        bus.b       = '0;
        bus.c_in    = 1'b0;
        bus.dec_add = 1'b0;
        bus.dec_sub = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, '0);
        chk("rst_flags", {bus.c_out, bus.v_out, bus.n_out, bus.z_out}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back sequence: each start lands on the previous done cycle.
        run_op("adc_bin",  kALU_ADC, 16'h12FF, 16'h0001, 0, 0, 0, 16'h1300, 4'b0000, 0);
        run_op("adc_dec1", kALU_ADC, 16'h0999, 16'h0001, 0, 1, 0, 16'h1000, 4'b0000, 0);
        run_op("adc_dec2", kALU_ADC, 16'h9999, 16'h0001, 0, 1, 0, 16'h0000, 4'b1001, 0);
        run_op("sbc_dec",  kALU_ADC, 16'h1000, 16'hFFFE, 1, 0, 1, 16'h0999, 4'b1000, 0);
        run_op("shr",      kALU_SHR, 16'h8001, 16'h0000, 1, 0, 0, 16'hC000, 4'b1010, 0);
        run_op("asr",      kALU_ASR, 16'h8001, 16'h0000, 0, 0, 0, 16'hC000, 4'b1010, 0);
        run_op("shl",      kALU_SHL, 16'h8001, 16'h0000, 0, 0, 0, 16'h0002, 4'b1000, 0);
        repeat (2) @(negedge clk);

        // Start raised during RUN must not launch a second operation.
        ds0 = done_seen;
        run_op("adc_ovf",  kALU_ADC, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 4'b0110, 1);
        repeat (6) @(negedge clk);
        chk("ignored_start_done_count", done_seen - ds0, 1);

        run_op("and_zero", kALU_AND, 16'h00F0, 16'h0F00, 0, 0, 0, 16'h0000, 4'b0001, 0);
        run_op("ora",      kALU_ORA, 16'h1234, 16'h00F0, 0, 0, 0, 16'h12F4, 4'b0000, 0);
        run_op("eor",      kALU_EOR, 16'hFFFF, 16'h0F0F, 1, 0, 0, 16'hF0F0, 4'b1010, 0);
        run_op("rsv",      kALU_RSV, 16'hABCD, 16'h1234, 1, 0, 0, 16'hABCD, 4'b1010, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        ds0         = done_seen;
        bus.start   = 1'b1;
        bus.op      = kALU_ADC;
        bus.a       = 16'h1234;
        bus.b       = 16'h4321;
        bus.c_in    = 1'b0;
        bus.dec_add = 1'b0;
        bus.dec_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("midrun_busy_before_reset", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrun_rst_busy", bus.busy, 1'b0);
        chk("midrun_rst_done", bus.done, 1'b0);
        chk("midrun_rst_result", bus.result, '0);
        chk("midrun_rst_flags", {bus.c_out, bus.v_out, bus.n_out, bus.z_out}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun_no_done_after_reset", done_seen - ds0, 0);

        run_op("adc_vz",   kALU_ADC, 16'h8000, 16'h8000, 0, 0, 0, 16'h0000, 4'b1101, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-byte successor to the single-byte ALU unit: a sequential ALU that executes one operation on a WORD_BYTES-wide operand pair, one byte per clock, using a shared 8-bit decimal-capable slice. It chains carry and shift bits between bytes and produces word-wide C/V/N/Z flags. It sits beside the byte ALU in the core and serves 16-bit and wider word operations under a start/busy/done handshake.

## Interface
- WORD_BYTES, 2, operand width in bytes (≥1); W = 8*WORD_BYTES
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when idle or done
- op  in  3  operation code, from shared package constants
- a  in  W  operand A (shift source)
- b  in  W  operand B; caller pre-inverts B for subtract
- c_in  in  1  carry in / shift fill bit
- dec_add  in  1  BCD add correction enable
- dec_sub  in  1  BCD subtract correction enable
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result and flags valid
- result  out  W  result word
- c_out, v_out, n_out, z_out  out  1 each  carry, overflow, result[W-1], result==0

## Operation
- Op codes: ORA=0, AND=1, EOR=2, ADC=3, SHR=4, ASR=5, SHL=6. Code 7 is reserved: result=a, c_out=c_in.
- States: IDLE -> RUN on start. RUN -> DONE after the last byte. DONE -> RUN if start is asserted, else IDLE.
- On acceptance, latch a, b, op, c_in, dec_add and dec_sub. Later input changes have no effect.
- Byte order: LSB first for ORA/AND/EOR/ADC/SHL/7; MSB first for SHR/ASR.
- ADC: byte i = a_i + b_i + chain carry. Chain starts at c_in.
  - Nibble carry = binary carry, or (dec_add and nibble sum > 9).
  - Each nibble then adds correction {sub_adj, add_adj, add_adj|sub_adj, 0}, where add_adj = dec_add & nibble carry and sub_adj = dec_sub & ~nibble carry, truncated to 4 bits.
  - Low-nibble correction uses the low-nibble carry; high-nibble correction uses the byte carry.
  - Byte carry feeds the next byte. The final byte carry is c_out.
- ORA/AND/EOR: bitwise per byte. c_out = ADC chain carry computed on the same latched operands.
- SHR: fill = c_in for the MSB byte; each byte's bit0 becomes the next lower byte's fill. c_out = a[0].
- ASR: as SHR, but fill = a[W-1].
- SHL: fill = c_in into the LSB byte; bit7 feeds the next byte. c_out = a[W-1].
- v_out = (a[W-1]==b[W-1]) & (a[W-1]!=result[W-1]), using the post-correction result. Valid for all ops; meaningful for ADC.
- z_out is a word-wide zero test, accumulated across bytes, not a per-byte test.
- result and flags hold from done until the next accepted start. During RUN they are undefined.

## Timing
- Start sampled high at edge k: busy=1 from k to k+WORD_BYTES. Byte j is written at edge k+1+j.
- done=1 from edge k+WORD_BYTES to k+WORD_BYTES+1. Latency is WORD_BYTES+1 clocks; busy=0 while done=1.
- Start while RUN is ignored (no queuing).
- Start during DONE is accepted: back-to-back throughput of one op per WORD_BYTES+1 clocks.
- Reset, asynchronous at any time including mid-RUN: state=IDLE, busy=0, done=0, result=0, all flags=0, byte index=0.
- WORD_BYTES=1: RUN lasts one cycle; behaviour equals the byte ALU plus the handshake.

## Structure
- Shared package alu_pkg holds the kALU_* op constants, the state enum {IDLE, RUN, DONE} and a byte-index width function (clog2, minimum 1).
- Sub-module alu_byte_slice is combinational. Inputs: a8, b8, fill/cin, op, dec_add, dec_sub. Outputs: y8, chain-out (carry or shifted-out bit).
- Top level owns the FSM, byte counter (ascending or descending), operand/result registers, and the carry and zero accumulators.

## Test plan
All scenarios use WORD_BYTES=2.
- Binary ADC 0x12FF+0x0001, c_in=0 -> result 0x1300, C=0, V=0, Z=0. done exactly 3 clocks after start.
- Decimal add 0x0999+0x0001 -> 0x1000, C=0. Decimal add 0x9999+0x0001 -> 0x0000, C=1, Z=1.
- Decimal subtract 1000-0001 (b=0xFFFE, c_in=1, dec_sub=1) -> 0x0999, C=1.
- SHR 0x8001, c_in=1 -> 0xC000, C=1. ASR 0x8001 -> 0xC000, C=1. SHL 0x8001, c_in=0 -> 0x0002, C=1, N=0.
- ADC 0x7FFF+0x0001 -> 0x8000, V=1, N=1, Z=0. AND 0x00F0&0x0F00 -> 0x0000, Z=1.
- Handshake:
  - Start pulsed mid-RUN is ignored.
  - Start during done starts the next op; its done follows 3 clocks later.
  - Reset asserted mid-RUN clears busy, done and result immediately, with no done pulse afterward.
